// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// Each grant is capped at HOLD_MAX accepted beats; release and rearbitration share one edge.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ready,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic [3:0] beats
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] beats_q, beats_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] pick;
  logic       rel;

  // Returns {found, index}; scanning backwards leaves the lowest offset from p as the winner.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    pick    = '0;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        beats_d = '0;
        gnt_d   = '0;
        pick    = rr_pick(req, ptr_q);
        if (pick[2]) begin
          state_d = GRANT;
          owner_d = pick[1:0];
          gnt_d   = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
        end
      end
      GRANT: begin
        // An owner drop outranks ready, so a dropping owner never gets a beat counted.
        rel = !req[owner_q] || (ready && (beats_q == LAST_BEAT));
        if (rel) begin
          ptr_d   = owner_q + 2'd1;
          pick    = rr_pick(req, owner_q + 2'd1);
          beats_d = '0;
          if (pick[2]) begin
            owner_d = pick[1:0];
            gnt_d   = 4'b0001 << pick[1:0];
            sel_d   = pick[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (ready) begin
          beats_d = beats_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        beats_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      beats_q <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = |gnt_q;
  assign beats = beats_q;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 mux datapath. Four requesters compete for the single mux output. The block grants one requester at a time, drives the mux select lines `s1`/`s0` to match, and bounds each grant to `HOLD_MAX` accepted beats so no requester starves. It sits directly in front of the mux select inputs; the mux itself stays purely combinational.

## Interface
- `HOLD_MAX`, default 4: maximum accepted beats per grant. Legal range 1..15; the beat counter is 4 bits.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 4: `req[k]` high means requester k wants the mux output. Requester k maps to mux input `i<k>`.
- `ready`, input, 1: downstream accepts the current mux output this cycle.
- `gnt`, output, 4: one-hot grant, or all zero when idle. Registered.
- `s1`, output, 1: mux select MSB. Registered; equals bit 1 of the granted index.
- `s0`, output, 1: mux select LSB. Registered; equals bit 0 of the granted index.
- `valid`, output, 1: equals `|gnt`. A beat transfers in any cycle where `valid && ready`.
- `beats`, output, 4: beats accepted so far in the current grant. Registered.

## Operation
- State machine with two states, IDLE and GRANT. Internal registers: `owner[1:0]` and round-robin pointer `ptr[1:0]`.
- **Arbitration function**, given `req` and `ptr`: the first index k in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `req[k]==1`. Wrap-around from 3 to 0 is required.
- **IDLE:**
  - No `req` bit set: stay IDLE, `gnt=0`, `beats=0`.
  - Any `req` bit set: next state GRANT. `owner` = arbitration result; `gnt` = one-hot of `owner`; `{s1,s0}=owner`; `beats=0`.
- **GRANT, at each edge, evaluated in this priority order:**
  1. `req[owner]==0`: release, and this edge counts no beat regardless of `ready`.
  2. `ready==1` and `beats==HOLD_MAX-1`: the beat is accepted, then release.
  3. `ready==1`: `beats` increments by 1 and the grant is held.
  4. `ready==0`: hold everything.
- **Release:**
  - `ptr` becomes `owner+1` (mod 4).
  - Rearbitrate in the same edge using the current `req` and the new `ptr`.
  - A winner moves directly to GRANT with `beats=0`, giving back-to-back grants with no bubble. The previous owner may win again only if it is the sole requester.
  - No winner: go to IDLE, `gnt=0`.
- `{s1,s0}` holds its last value while IDLE, so the mux output is don't-care when `valid=0`.
- `gnt` must never have more than one bit set.
- Requests from non-owners are ignored until release.

## Timing
- Reset values while `rst_n=0`, applied immediately without waiting for a clock edge:
  - `gnt=0000`, `s1=0`, `s0=0`, `valid=0`, `beats=0`.
  - `ptr=0`, `owner=0`, state IDLE.
- Reset asserted mid-grant aborts the grant at once. The first edge after `rst_n` rises arbitrates from `ptr=0`.
- Grant latency: `req` sampled high at edge N while IDLE gives `gnt`/`s1`/`s0` valid after edge N, i.e. one cycle.
- Select lines change in the same cycle as `gnt`. The mux output is valid for the new owner throughout that cycle.
- Maximum grant duration is `HOLD_MAX` accepted beats. With `ready` low, the grant holds indefinitely while `req[owner]` stays high.
- Owner drop: `req[owner]` low at edge N means `gnt` moves or clears after edge N. The requester must not expect a beat at edge N.
- Simultaneous owner drop and `ready`: the drop wins, and no beat is counted.

## Test plan
- **Reset mid-grant.** Reset, then `req=0010`, `ready=1`, and assert `rst_n=0` mid-grant. Required:
  - `gnt=0010`, `{s1,s0}=01` one cycle after `req` is sampled.
  - `beats` counts 0,1,2,3 on consecutive cycles.
  - `gnt` clears immediately when `rst_n` falls.
- **HOLD_MAX rotation.** `req=1111` held, `ready=1`, `HOLD_MAX=4`. Required: grants rotate 0,1,2,3,0, each lasting exactly 4 cycles, with `{s1,s0}` following 00,01,10,11,00 and no idle cycle between grants.
- **Wrap-around.** Grant 3 to completion with `req=1001`. Required: the next grant goes to 0 (`gnt=0001`, `{s1,s0}=00`), not back to 3.
- **Backpressure.** `req=0100`, `ready` pattern 1,0,0,1,1,1 after the grant. Required:
  - `beats` goes 1,1,1,2,3 and the grant is held through the stall.
  - Release occurs on the 4th accepted beat, then IDLE (`gnt=0`, `{s1,s0}` held at 10).
- **Owner drop with ready.** Owner 1 drops `req` at the same edge that `ready=1`, while `req[2]=1`. Required: no beat is counted, and the next cycle shows `gnt=0100`, `{s1,s0}=10`, `beats=0`.
- **Sole requester.** Only `req[0]` stays high for 10 cycles with `ready=1` and `HOLD_MAX=4`. Required: `gnt=0001` is continuous, and `beats` cycles 0,1,2,3,0,1,2,3,0,1 as it is re-granted to itself.
